// File: rtl/apb_arbiter.sv
// Two-port round-robin APB arbiter. It serialises upstream transfers onto one downstream APB
// slave and returns each response to the granted port through registered outputs.
module apb_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              S0_PSEL,
    input  logic              S0_PENABLE,
    input  logic [AW-1:0]     S0_PADDR,
    input  logic              S0_PWRITE,
    input  logic [DW-1:0]     S0_PWDATA,
    input  logic [DW/8-1:0]   S0_PWSTRB,
    input  logic [2:0]        S0_PPROT,
    output logic              S0_PREADY,
    output logic [DW-1:0]     S0_PRDATA,
    output logic              S0_PSLVERR,
    input  logic              S1_PSEL,
    input  logic              S1_PENABLE,
    input  logic [AW-1:0]     S1_PADDR,
    input  logic              S1_PWRITE,
    input  logic [DW-1:0]     S1_PWDATA,
    input  logic [DW/8-1:0]   S1_PWSTRB,
    input  logic [2:0]        S1_PPROT,
    output logic              S1_PREADY,
    output logic [DW-1:0]     S1_PRDATA,
    output logic              S1_PSLVERR,
    output logic              M_PSEL,
    output logic              M_PENABLE,
    output logic              M_PWRITE,
    output logic [AW-1:0]     M_PADDR,
    output logic [DW-1:0]     M_PWDATA,
    output logic [DW/8-1:0]   M_PWSTRB,
    output logic [2:0]        M_PPROT,
    input  logic              M_PREADY,
    input  logic              M_PSLVERR,
    input  logic [DW-1:0]     M_PRDATA
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e            state_q;
    logic              grant_q, last_grant_q;
    logic              m_psel_q, m_penable_q, m_pwrite_q;
    logic [AW-1:0]     m_paddr_q;
    logic [DW-1:0]     m_pwdata_q;
    logic [DW/8-1:0]   m_pwstrb_q;
    logic [2:0]        m_pprot_q;
    logic              s0_pready_q, s0_pslverr_q, s1_pready_q, s1_pslverr_q;
    logic [DW-1:0]     s0_prdata_q, s1_prdata_q;

    logic              grant_d;
    logic              req_any;
    logic              pwrite_d;
    logic [AW-1:0]     paddr_d;
    logic [DW-1:0]     pwdata_d;
    logic [DW/8-1:0]   pwstrb_d;
    logic [2:0]        pprot_d;

    // PENABLE does not matter: a SETUP or a stalled ACCESS are both just requests.
    logic unused_penable;
    assign unused_penable = S0_PENABLE ^ S1_PENABLE;

    always_comb begin
        req_any = S0_PSEL | S1_PSEL;
        if (S0_PSEL && S1_PSEL) grant_d = ~last_grant_q;
        else                    grant_d = S1_PSEL;
        paddr_d  = grant_d ? S1_PADDR  : S0_PADDR;
        pwrite_d = grant_d ? S1_PWRITE : S0_PWRITE;
        pwdata_d = grant_d ? S1_PWDATA : S0_PWDATA;
        pwstrb_d = grant_d ? S1_PWSTRB : S0_PWSTRB;
        pprot_d  = grant_d ? S1_PPROT  : S0_PPROT;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            m_psel_q     <= 1'b0;
            m_penable_q  <= 1'b0;
            m_pwrite_q   <= 1'b0;
            m_paddr_q    <= '0;
            m_pwdata_q   <= '0;
            m_pwstrb_q   <= '0;
            m_pprot_q    <= '0;
            s0_pready_q  <= 1'b0;
            s0_pslverr_q <= 1'b0;
            s0_prdata_q  <= '0;
            s1_pready_q  <= 1'b0;
            s1_pslverr_q <= 1'b0;
            s1_prdata_q  <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_any) begin
                        grant_q      <= grant_d;
                        last_grant_q <= grant_d;
                        m_psel_q     <= 1'b1;
                        m_penable_q  <= 1'b0;
                        m_pwrite_q   <= pwrite_d;
                        m_paddr_q    <= paddr_d;
                        m_pwdata_q   <= pwdata_d;
                        m_pwstrb_q   <= pwstrb_d;
                        m_pprot_q    <= pprot_d;
                        state_q      <= StSetup;
                    end
                end
                StSetup: begin
                    m_penable_q <= 1'b1;
                    state_q     <= StAccess;
                end
                StAccess: begin
                    if (M_PREADY) begin
                        m_psel_q    <= 1'b0;
                        m_penable_q <= 1'b0;
                        if (OPT_LOWPOWER) begin
                            m_pwrite_q <= 1'b0;
                            m_paddr_q  <= '0;
                            m_pwdata_q <= '0;
                            m_pwstrb_q <= '0;
                            m_pprot_q  <= '0;
                        end
                        if (grant_q) begin
                            s1_pready_q  <= 1'b1;
                            s1_pslverr_q <= M_PSLVERR;
                            s1_prdata_q  <= M_PRDATA;
                        end else begin
                            s0_pready_q  <= 1'b1;
                            s0_pslverr_q <= M_PSLVERR;
                            s0_prdata_q  <= M_PRDATA;
                        end
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    s0_pready_q  <= 1'b0;
                    s0_pslverr_q <= 1'b0;
                    s1_pready_q  <= 1'b0;
                    s1_pslverr_q <= 1'b0;
                    if (OPT_LOWPOWER) begin
                        s0_prdata_q <= '0;
                        s1_prdata_q <= '0;
                    end
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign M_PSEL     = m_psel_q;
    assign M_PENABLE  = m_penable_q;
    assign M_PWRITE   = m_pwrite_q;
    assign M_PADDR    = m_paddr_q;
    assign M_PWDATA   = m_pwdata_q;
    assign M_PWSTRB   = m_pwstrb_q;
    assign M_PPROT    = m_pprot_q;
    assign S0_PREADY  = s0_pready_q;
    assign S0_PSLVERR = s0_pslverr_q;
    assign S0_PRDATA  = s0_prdata_q;
    assign S1_PREADY  = s1_pready_q;
    assign S1_PSLVERR = s1_pslverr_q;
    assign S1_PRDATA  = s1_prdata_q;

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
Two-requester APB arbiter/sequencer that shares one downstream APB slave.
- Each upstream port is an APB slave interface facing a master.
- The downstream port is an APB master interface that generates legal SETUP/ACCESS phases for one transaction at a time.
- Arbitration is round-robin.
- Responses return to the granted requester through a registered stage. Upstream and downstream timing are therefore fully decoupled.

Parameters:
AW, 32, address width
DW, 32, data width (multiple of 8)
OPT_LOWPOWER, 1'b0, when set, M_PADDR/M_PWDATA/M_PWSTRB/M_PPROT/M_PWRITE are zero whenever M_PSEL is low, and Sx_PRDATA is zero whenever Sx_PREADY is low

Ports:
PCLK  input  1  clock
PRESETn  input  1  reset, asynchronous, active-low
S0_PSEL / S1_PSEL  input  1  upstream select
S0_PENABLE / S1_PENABLE  input  1  upstream access phase
S0_PADDR / S1_PADDR  input  AW  upstream address
S0_PWRITE / S1_PWRITE  input  1  upstream write flag
S0_PWDATA / S1_PWDATA  input  DW  upstream write data
S0_PWSTRB / S1_PWSTRB  input  DW/8  upstream byte strobes
S0_PPROT / S1_PPROT  input  3  upstream protection
S0_PREADY / S1_PREADY  output  1  upstream completion, registered
S0_PRDATA / S1_PRDATA  output  DW  upstream read data, registered
S0_PSLVERR / S1_PSLVERR  output  1  upstream error, registered
M_PSEL, M_PENABLE, M_PWRITE  output  1  downstream control, registered
M_PADDR  output  AW; M_PWDATA  output  DW; M_PWSTRB  output  DW/8; M_PPROT  output  3  downstream request, registered
M_PREADY, M_PSLVERR  input  1; M_PRDATA  input  DW  downstream response

Behaviour:
Reset (PRESETn low, asynchronous): all outputs 0; state=IDLE; last_grant=1, so S0 wins the first tie.

State machine: IDLE, SETUP, ACCESS, RESP.
- IDLE
  - req0=S0_PSEL, req1=S1_PSEL. PENABLE is ignored, so an upstream in SETUP or a stalled ACCESS both count as a request.
  - No request: remain in IDLE.
  - One request: grant it.
  - Both request: grant the port != last_grant.
  - On grant, at the same edge: latch PADDR/PWRITE/PPROT and PWDATA/PWSTRB of the granted port into the M_ registers; set grant and last_grant; M_PSEL<=1, M_PENABLE<=0; go to SETUP.
- SETUP
  - M_PENABLE<=1; go to ACCESS.
  - Request fields hold.
- ACCESS
  - Hold all M_ outputs while M_PREADY=0. There is no timeout.
  - On M_PREADY=1: capture M_PRDATA and M_PSLVERR into the granted port's response regs; M_PSEL<=0, M_PENABLE<=0; assert Sgrant_PREADY<=1; go to RESP.
  - Back-to-back downstream transfers are not issued: M_PSEL always deasserts for at least one cycle between transfers.
- RESP
  - Sgrant_PREADY=1 for exactly one cycle, with PRDATA and PSLVERR valid.
  - Next edge: PREADY<=0, PSLVERR<=0; go to IDLE.

Upstream handling:
- The non-granted port, and the granted port outside RESP, see PREADY=0. Its APB stall is legal; its inputs are held by protocol.
- Sx_PSLVERR is high only in RESP and only for the granted port.
- Sx_PRDATA holds its last value unless OPT_LOWPOWER is set.

Latency and fairness:
- Upstream PSEL rising in cycle t with an immediately-ready slave gives Sx_PREADY in cycle t+3. M_PSEL is high in t+1..t+2 and M_PENABLE in t+2.
- A port releases its grant after each transfer. With both ports saturated, grants strictly alternate.
- The maximum wait for a port is one full transfer of the other port.

Read/write:
- PWDATA and PWSTRB are forwarded regardless of PWRITE.
- On reads the downstream values are don't-care but stable.

Other rules:
- An upstream PSEL dropping while not granted is tolerated: no request is recorded, and nothing is queued.
- Reset asserted mid-transfer aborts it: M_PSEL drops immediately and no upstream PREADY is generated.

Test Plan:
1. S0 write, addr 0x10, data 0xA5A5A5A5, M_PREADY=1 immediately: M_PSEL in t+1..t+2, M_PENABLE in t+2, M_PADDR=0x10, M_PWDATA=0xA5A5A5A5; S0_PREADY=1 in t+3 only; S1_PREADY stays 0.
2. S1 read, addr 0x20, M_PREADY low for 3 ACCESS cycles, then M_PRDATA=0xDEADBEEF with M_PSLVERR=1: M_ outputs stable throughout the stall; then one RESP cycle with S1_PRDATA=0xDEADBEEF and S1_PSLVERR=1.
3. S0 and S1 both raise PSEL in the same cycle from reset: S0 served first. S1 is granted in the IDLE cycle after S0's RESP, and its downstream transfer starts the next cycle.
4. Both ports issuing continuous transfers for 8 transactions: grant sequence S0,S1,S0,S1,...; M_PSEL low for at least one cycle between transfers.
5. PRESETn pulsed low during ACCESS with M_PREADY=0: all outputs 0 asynchronously; no upstream PREADY after release; the next request begins from IDLE with S0 priority.
6. Formal check: bind an APB slave-side protocol checker on M_ and an APB master-side checker on each S port. All properties hold; max upstream stall ≤ 2×(downstream stall bound + 3).
